icache: RTL and testbench

Direct-mapped, read-only instruction cache between the instruction-fetch unit and the memory controller. Fetch requests are served with a one-cycle-latency word on a hit. On a miss the cache issues a 16-byte line-fill request to the memory controller's fetch channel, installs the returned line, and forwards the requested word. A rollback input discards any pending response without corrupting the fill in flight.

---
 rtl/icache.sv | 126 ++++++++++++
 tb/tb_icache.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: one-cycle hits, 16-byte line fills
// from the memory controller on a miss, with rollback that suppresses the response.
module icache #(
    parameter int ICACHE_LINES = 64,
    parameter int IDX_W        = $clog2(ICACHE_LINES),
    parameter int TAG_W        = 28 - IDX_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    input  logic         if_valid,
    input  logic [31:0]  if_addr,
    input  logic         ic_rb,
    output logic         if_done,
    output logic [31:0]  if_inst,
    output logic         icache_fc_valid,
    output logic [31:0]  icache_fc_addr,
    input  logic         icache_fc_done,
    input  logic [127:0] icache_fc_line
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FETCH = 1'b1;

    logic [0:0]              state_q, state_d;
    logic                    discard_q, discard_d;
    logic [31:2]             addr_q, addr_d;
    logic [ICACHE_LINES-1:0] valid_q, valid_d;
    logic                    if_done_q, if_done_d;
    logic [31:0]             if_inst_q, if_inst_d;
    logic                    fc_valid_q, fc_valid_d;
    logic [31:0]             fc_addr_q, fc_addr_d;

    logic [TAG_W-1:0] tag_arr  [ICACHE_LINES];
    logic [127:0]     data_arr [ICACHE_LINES];

    logic [IDX_W-1:0] req_idx, fill_idx;
    logic [TAG_W-1:0] req_tag, fill_tag;
    logic [127:0]     req_line;
    logic             req_hit, accept, fill_we;
    logic             unused_addr_bits;

    assign req_idx  = if_addr[4+IDX_W-1:4];
    assign req_tag  = if_addr[31:4+IDX_W];
    assign fill_idx = addr_q[4+IDX_W-1:4];
    assign fill_tag = addr_q[31:4+IDX_W];
    assign req_line = data_arr[req_idx];
    assign req_hit  = valid_q[req_idx] && (tag_arr[req_idx] == req_tag);
    assign accept   = (state_q == IDLE) && if_valid && !if_done_q && !ic_rb;
    assign fill_we  = (state_q == FETCH) && icache_fc_done;
    assign unused_addr_bits = ^if_addr[1:0];

    always_comb begin
        state_d    = state_q;
        discard_d  = discard_q;
        addr_d     = addr_q;
        valid_d    = valid_q;
        if_done_d  = 1'b0;
        if_inst_d  = if_inst_q;
        fc_valid_d = fc_valid_q;
        fc_addr_d  = fc_addr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_hit) begin
                        if_done_d = 1'b1;
                        if_inst_d = req_line[32*if_addr[3:2] +: 32];
                    end else begin
                        addr_d     = if_addr[31:2];
                        fc_valid_d = 1'b1;
                        fc_addr_d  = {if_addr[31:4], 4'h0};
                        discard_d  = 1'b0;
                        state_d    = FETCH;
                    end
                end
            end
            default: begin
                // Rollback only silences the response; the fill still completes and installs.
                if (ic_rb)
                    discard_d = 1'b1;
                if (icache_fc_done) begin
                    valid_d[fill_idx] = 1'b1;
                    fc_valid_d        = 1'b0;
                    state_d           = IDLE;
                    if (!discard_q && !ic_rb) begin
                        if_done_d = 1'b1;
                        if_inst_d = icache_fc_line[32*addr_q[3:2] +: 32];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            discard_q  <= 1'b0;
            addr_q     <= '0;
            valid_q    <= '0;
            if_done_q  <= 1'b0;
            if_inst_q  <= '0;
            fc_valid_q <= 1'b0;
            fc_addr_q  <= '0;
        end else if (rdy) begin
            state_q    <= state_d;
            discard_q  <= discard_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            if_done_q  <= if_done_d;
            if_inst_q  <= if_inst_d;
            fc_valid_q <= fc_valid_d;
            fc_addr_q  <= fc_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && fill_we) begin
            data_arr[fill_idx] <= icache_fc_line;
            tag_arr[fill_idx]  <= fill_tag;
        end
    end

    assign if_done         = if_done_q;
    assign if_inst         = if_inst_q;
    assign icache_fc_valid = fc_valid_q;
    assign icache_fc_addr  = fc_addr_q;
endmodule

// File: tb/tb_icache.sv
// Randomized bench for icache: a line-granular model of the cache contents and a
// behavioural memory controller decide when each fetch must hit, miss or stay silent.
module tb_icache;
    logic         clk = 1'b0;
    logic         rst, rdy, if_valid, ic_rb, icache_fc_done;
    logic [31:0]  if_addr;
    logic         if_done, icache_fc_valid;
    logic [31:0]  if_inst, icache_fc_addr;
    logic [127:0] icache_fc_line;

    int checks = 0;
    int errors = 0;

    // Model: which memory line currently lives in each of the 64 cache slots.
    logic        m_valid [64];
    logic [27:0] m_line  [64];

    icache dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_valid(if_valid), .if_addr(if_addr), .ic_rb(ic_rb),
        .if_done(if_done), .if_inst(if_inst),
        .icache_fc_valid(icache_fc_valid), .icache_fc_addr(icache_fc_addr),
        .icache_fc_done(icache_fc_done), .icache_fc_line(icache_fc_line)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mem_line(input logic [31:0] a);
        logic [127:0] l;
        if (a[31:4] == 28'h0)
            return 128'h44444444_33333333_22222222_11111111;
        for (int w = 0; w < 4; w++)
            l[32*w +: 32] = ({a[31:4], 4'h0} ^ 32'hA5A50000) * 32'h9E3779B1 + w * 32'h01010101;
        return l;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    endtask

    // mode: 0 normal, 1 rollback during the fill, 2 rollback on the same edge as the fill completes
    task automatic fetch(input logic [31:0] a, input int mode);
        logic         hit;
        logic [127:0] line;
        logic [31:0]  word;
        int           dly;
        hit  = m_valid[a[9:4]] && (m_line[a[9:4]] == a[31:4]);
        line = mem_line(a);
        word = line[32*a[3:2] +: 32];
        @(negedge clk);
        if_valid = 1'b1;
        if_addr  = a;
        @(negedge clk);
        if (hit) begin
            check_eq("hit_done", {31'b0, if_done}, 32'd1);
            check_eq("hit_inst", if_inst, word);
            check_eq("hit_fc_valid", {31'b0, icache_fc_valid}, 32'd0);
            if_valid = 1'b0;
            @(negedge clk);
            check_eq("hit_pulse", {31'b0, if_done}, 32'd0);
            $display("fetch %h hit inst=%h", a, if_inst);
        end else begin
            check_eq("miss_done", {31'b0, if_done}, 32'd0);
            check_eq("miss_fc_valid", {31'b0, icache_fc_valid}, 32'd1);
            check_eq("miss_fc_addr", icache_fc_addr, {a[31:4], 4'h0});
            dly = $urandom_range(3, 6);
            for (int i = 0; i < dly; i++) begin
                if (mode == 1 && i == 1) begin
                    ic_rb    = 1'b1;
                    if_valid = 1'b0;
                end
                @(negedge clk);
                ic_rb = 1'b0;
            end
            check_eq("fill_held", {31'b0, icache_fc_valid}, 32'd1);
            check_eq("fill_addr_held", icache_fc_addr, {a[31:4], 4'h0});
            icache_fc_done = 1'b1;
            icache_fc_line = line;
            if (mode == 2) begin
                ic_rb    = 1'b1;
                if_valid = 1'b0;
            end
            @(negedge clk);
            icache_fc_done = 1'b0;
            ic_rb          = 1'b0;
            check_eq("fill_drop", {31'b0, icache_fc_valid}, 32'd0);
            check_eq("miss_resp", {31'b0, if_done}, (mode == 0) ? 32'd1 : 32'd0);
            if (mode == 0) check_eq("miss_inst", if_inst, word);
            if_valid = 1'b0;
            m_valid[a[9:4]] = 1'b1;
            m_line[a[9:4]]  = a[31:4];
            @(negedge clk);
            check_eq("miss_pulse", {31'b0, if_done}, 32'd0);
            $display("fetch %h miss mode=%0d dly=%0d inst=%h", a, mode, dly, if_inst);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_eq("rst_done", {31'b0, if_done}, 32'd0);
        check_eq("rst_inst", if_inst, 32'd0);
        check_eq("rst_fc_valid", {31'b0, icache_fc_valid}, 32'd0);
        check_eq("rst_fc_addr", icache_fc_addr, 32'd0);
        $display("reset outputs done=%b inst=%h fcv=%b fca=%h", if_done, if_inst, icache_fc_valid, icache_fc_addr);
    endtask

    initial begin
        logic [31:0] a;
        rst = 1'b1; rdy = 1'b1; if_valid = 1'b0; if_addr = '0; ic_rb = 1'b0;
        icache_fc_done = 1'b0; icache_fc_line = '0;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        fetch(32'h0000_0004, 0);
        fetch(32'h0000_000C, 0);
        fetch(32'h0000_0400, 0);
        fetch(32'h0000_0000, 0);
        fetch(32'h0000_1000, 1);
        fetch(32'h0000_1008, 0);
        fetch(32'h0000_2000, 2);
        fetch(32'h0000_2004, 0);

        // Rollback in IDLE blocks acceptance of a request that would otherwise hit.
        @(negedge clk);
        if_valid = 1'b1; if_addr = 32'h0000_2008; ic_rb = 1'b1;
        @(negedge clk);
        if_valid = 1'b0; ic_rb = 1'b0;
        check_eq("idle_rb_done", {31'b0, if_done}, 32'd0);
        check_eq("idle_rb_fcv", {31'b0, icache_fc_valid}, 32'd0);
        $display("idle rollback done=%b", if_done);

        // With rdy low the request is not seen; once rdy returns it hits.
        @(negedge clk);
        rdy = 1'b0; if_valid = 1'b1; if_addr = 32'h0000_200C;
        repeat (2) @(negedge clk);
        check_eq("frozen_done", {31'b0, if_done}, 32'd0);
        rdy = 1'b1;
        @(negedge clk);
        if_valid = 1'b0;
        check_eq("thaw_done", {31'b0, if_done}, 32'd1);
        check_eq("thaw_inst", if_inst, mem_line(32'h2000) >> 96);
        @(negedge clk);
        $display("rdy freeze inst=%h", if_inst);

        do_reset();
        fetch(32'h0000_0004, 0);

        // Reset in the middle of a fill abandons it.
        @(negedge clk);
        if_valid = 1'b1; if_addr = 32'h0000_3000;
        @(negedge clk);
        check_eq("pre_rst_fcv", {31'b0, icache_fc_valid}, 32'd1);
        if_valid = 1'b0;
        do_reset();

        for (int n = 0; n < 200; n++) begin
            a = {20'h0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 2'($urandom), 2'b00};
            if ($urandom_range(0, 1) == 1) a[31:12] = 20'hABCDE;
            fetch(a, ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
